// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 8-bit register-file/ALU datapath: accepts one word per
// handshake, registers the decoded control fields and issues a single negedge-launched write.
module datapath_sequencer #(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [16:0]            instr,
    output logic                   writeEnable,
    output logic                   muxSel,
    output logic [7:0]             inputData,
    output logic [3:0]             dstSel,
    output logic [3:0]             A_sel,
    output logic [3:0]             B_sel,
    output logic [3:0]             OP_Sel,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {StIdle, StSetup, StWrite} state_e;

    state_e                 r_state;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_we;
    logic                   r_mux;
    logic [7:0]             r_data;
    logic [3:0]             r_dst;
    logic [3:0]             r_a;
    logic [3:0]             r_b;
    logic [3:0]             r_op;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_accept;

    // Field bit i of the word keeps index i on the port (bit 0 = IMM, 1..4 = DST, ...).
    assign w_accept = instr_valid & r_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mux   <= 1'b0;
            r_data  <= '0;
            r_dst   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= StSetup;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_dst   <= instr[4:1];
                        if (instr[0]) begin
                            r_mux  <= 1'b1;
                            r_data <= instr[12:5];
                        end else begin
                            r_mux <= 1'b0;
                            r_a   <= instr[8:5];
                            r_b   <= instr[12:9];
                            r_op  <= instr[16:13];
                        end
                    end
                end
                StSetup: begin
                    r_state <= StWrite;
                end
                StWrite: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_count <= r_count + 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Launched on the falling edge so the gated write clock (clk & writeEnable) never glitches.
    always_ff @(negedge clk) begin
        r_we <= (r_state == StSetup) & ~reset;
    end

    assign instr_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign writeEnable = r_we;
    assign muxSel      = r_mux;
    assign inputData   = r_data;
    assign dstSel      = r_dst;
    assign A_sel       = r_a;
    assign B_sel       = r_b;
    assign OP_Sel      = r_op;
    assign instr_count = r_count;

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Instruction sequencer for the 8-bit register-file/ALU datapath. It accepts one instruction word at a time over a valid/ready handshake and decodes it into the datapath control fields. It drives the datapath's `writeEnable`, `muxSel`, `inputData`, `dstSel`, `A_sel`, `B_sel` and `OP_Sel` inputs so that each instruction produces exactly one glitch-free register write. The datapath gates its write clock as `clk AND writeEnable`, so this block owns the timing of `writeEnable` relative to `clk`.

## Interface
Parameters:
- `COUNT_WIDTH`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock. Also clocks the datapath.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word present.
- `instr_ready`  out  1  sequencer can accept a word this cycle.
- `instr`  in  17  instruction word `[0:16]`:
  - bit 0 = IMM;
  - bits 1:4 = DST;
  - bits 5:8 = A;
  - bits 9:12 = B;
  - bits 13:16 = OP.
  - When IMM=1, bits 5:12 carry the 8-bit immediate.
- `writeEnable`  out  1  datapath write enable (negedge-launched, see Timing).
- `muxSel`  out  1  1 = write `inputData`, 0 = write ALU result.
- `inputData`  out  8  immediate value `[0:7]`.
- `dstSel`, `A_sel`, `B_sel`, `OP_Sel`  out  4 each  datapath selects `[0:3]`.
- `busy`  out  1  instruction in flight.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `instr_count`  out  COUNT_WIDTH  retired-instruction count.

## Operation
- FSM states: IDLE, SETUP, WRITE.
- **IDLE:**
  - `instr_ready`=1, `busy`=0.
  - On `instr_valid & instr_ready`, latch the decoded fields and go to SETUP.
- **SETUP:** selects are stable; `writeEnable` rises on the falling edge of `clk`. Next state is WRITE.
- **WRITE:**
  - The register file wrote on the rising `clk` edge that entered this state.
  - `writeEnable` falls on this state's falling edge.
  - Next state is IDLE, with `done`=1 and `instr_count` += 1 on that transition.
- **Decode when IMM=1:**
  - `muxSel`=1.
  - `inputData`=`instr[5:12]`.
  - `dstSel`=DST.
  - `A_sel`, `B_sel`, `OP_Sel` hold their previous values (don't-care to the datapath).
- **Decode when IMM=0:**
  - `muxSel`=0.
  - `dstSel`/`A_sel`/`B_sel`/`OP_Sel` = DST/A/B/OP.
  - `inputData` holds its previous value.
- All select outputs are registered. They change only on the accepting posedge and hold until the next accept.
- `instr_ready`=0 in SETUP and WRITE. `instr_valid` is ignored there; the word must be held by the producer.
- `instr_count` wraps from 2^COUNT_WIDTH−1 to 0 silently.
- `done` and the count increment occur in the same cycle (the first IDLE cycle after WRITE).

## Timing
- Reset values:
  - state IDLE;
  - `writeEnable`=0, `muxSel`=0;
  - `inputData`=0, all selects 0;
  - `busy`=0, `done`=0, `instr_count`=0;
  - `instr_ready`=1 (in the cycle after reset deasserts).
- `writeEnable` comes from a falling-edge flop whose D input is `(state==SETUP) & ~reset`. It is therefore stable across every rising edge and never produces a partial gated-clock pulse.
- Per-instruction timeline: accept at posedge k → SETUP; register write at posedge k+1 → WRITE; posedge k+2 → IDLE with `done`=1.
- Throughput: one instruction per 3 cycles. A new accept can occur at posedge k+3 at the earliest.
- Back-to-back valid: the word presented during SETUP/WRITE is accepted at the first IDLE posedge (k+3, the cycle `done` is high).
- **Reset mid-operation:**
  - Reset sampled at posedge k+1 (during SETUP): the write at k+1 still occurs because `writeEnable` is already high. The FSM goes to IDLE, with no `done` and no count increment.
  - Reset sampled at posedge k+2 (during WRITE): go to IDLE, with no `done` and no increment.
  - Reset held across the negedge in SETUP suppresses `writeEnable`.
- Reset has priority over accept in the same cycle; the offered word is not accepted.

## Test plan
- **Reset:** hold `reset` 2 cycles → all outputs 0, `instr_ready`=1 the cycle after release, `instr_count`=0.
- **Immediate load:** `instr` IMM=1, DST=3, imm=0xA5 → `muxSel`=1, `inputData`=0xA5, `dstSel`=3. Exactly one `writeEnable` high phase spanning posedge k+1. `done` at k+2. Datapath register 3 = 0xA5.
- **ALU op:** after loading r1=0x0F and r2=0x01, issue IMM=0, DST=4, A=1, B=2, OP=add code → `muxSel`=0, selects 4/1/2/OP. Register 4 = 0x10 after WRITE. `instr_count`=3.
- **Streaming:** `instr_valid` held high with 4 distinct words → accepts at cycles 0, 3, 6, 9. `instr_ready` low in between. 4 `done` pulses. The word is not consumed while `instr_ready`=0.
- **Reset mid-op:** assert reset at posedge k+1 → write at k+1 occurs, no `done`, count unchanged. Assert reset at posedge k (with valid) → no accept, `writeEnable` never rises.
- **Counter wrap:** with `COUNT_WIDTH`=2, retire 5 instructions → `instr_count` sequence 1,2,3,0,1.
